// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding select generation, load-use stall detection and
// branch/jump flush control, with saturating stall/flush event counters.
module fwd_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_id,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             rs1_used_id,
  input  logic             rs2_used_id,
  input  logic [4:0]       rd_id,
  input  logic             reg_write_id,
  input  logic             mem_read_id,
  input  logic             use_pc_id,
  input  logic             use_imm_id,
  input  logic             pc_select,
  output logic [1:0]       data1_sel_ALU,
  output logic [1:0]       data2_sel_ALU,
  output logic [1:0]       data1_sel_BJ,
  output logic [1:0]       data2_sel_BJ,
  output logic             stall,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_ALT = 2'd1;
  localparam logic [1:0] SEL_WB  = 2'd2;
  localparam logic [1:0] SEL_MEM = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } shadow_t;

  shadow_t    ex_q;
  shadow_t    mem_q;
  shadow_t    id_entry;
  logic       ex_hit1;
  logic       ex_hit2;
  logic       mem_hit1;
  logic       mem_hit2;
  logic [1:0] fwd1;
  logic [1:0] fwd2;
  logic       load_use;
  logic       issue;

  function automatic logic src_hit(input shadow_t e, input logic [4:0] src,
                                   input logic used);
    return e.valid && e.reg_write && (e.rd != 5'd0) && (e.rd == src) && used;
  endfunction

  // ex_q holds the next-older instruction, so it outranks mem_q.
  always_comb begin
    ex_hit1  = src_hit(ex_q, rs1_id, rs1_used_id);
    ex_hit2  = src_hit(ex_q, rs2_id, rs2_used_id);
    mem_hit1 = src_hit(mem_q, rs1_id, rs1_used_id);
    mem_hit2 = src_hit(mem_q, rs2_id, rs2_used_id);
    fwd1 = SEL_RF;
    fwd2 = SEL_RF;
    if (ex_hit1)       fwd1 = SEL_MEM;
    else if (mem_hit1) fwd1 = SEL_WB;
    if (ex_hit2)       fwd2 = SEL_MEM;
    else if (mem_hit2) fwd2 = SEL_WB;
  end

  assign load_use    = valid_id && ex_q.valid && ex_q.mem_read && (ex_hit1 || ex_hit2);
  assign stall       = load_use && !pc_select;
  assign flush_if_id = pc_select;
  assign flush_id_ex = pc_select;
  assign issue       = valid_id && !pc_select && !stall;
  assign id_entry    = {1'b1, rd_id, reg_write_id, mem_read_id};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q          <= '0;
      mem_q         <= '0;
      data1_sel_ALU <= SEL_RF;
      data2_sel_ALU <= SEL_RF;
      data1_sel_BJ  <= SEL_RF;
      data2_sel_BJ  <= SEL_RF;
    end else begin
      mem_q <= ex_q;
      if (issue) begin
        ex_q          <= id_entry;
        data1_sel_ALU <= use_pc_id ? SEL_ALT : fwd1;
        data2_sel_ALU <= use_imm_id ? SEL_ALT : fwd2;
        data1_sel_BJ  <= fwd1;
        data2_sel_BJ  <= fwd2;
      end else begin
        ex_q          <= '0;
        data1_sel_ALU <= SEL_RF;
        data2_sel_ALU <= SEL_RF;
        data1_sel_BJ  <= SEL_RF;
        data2_sel_BJ  <= SEL_RF;
      end
    end
  end

  // Counters stick at all-ones so a long run never reads back as a small count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && (stall_count != CNT_MAX))
        stall_count <= stall_count + CNT_ONE;
      if (pc_select && (flush_count != CNT_MAX))
        flush_count <= flush_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: hand-computed instruction table, saturation and
// reset-mid-stall sequences, then random traffic against a history-based model.
module tb_fwd_hazard_ctrl;

  localparam int CNT_W   = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             valid_id;
  logic [4:0]       rs1_id, rs2_id, rd_id;
  logic             rs1_used_id, rs2_used_id;
  logic             reg_write_id, mem_read_id, use_pc_id, use_imm_id, pc_select;
  logic [1:0]       data1_sel_ALU, data2_sel_ALU, data1_sel_BJ, data2_sel_BJ;
  logic             stall, flush_if_id, flush_id_ex;
  logic [CNT_W-1:0] stall_count, flush_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .valid_id(valid_id),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .rd_id(rd_id), .reg_write_id(reg_write_id), .mem_read_id(mem_read_id),
    .use_pc_id(use_pc_id), .use_imm_id(use_imm_id), .pc_select(pc_select),
    .data1_sel_ALU(data1_sel_ALU), .data2_sel_ALU(data2_sel_ALU),
    .data1_sel_BJ(data1_sel_BJ), .data2_sel_BJ(data2_sel_BJ),
    .stall(stall), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  typedef struct {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       use_pc;
    logic       use_imm;
    logic       psel;
  } ins_t;

  typedef struct {
    ins_t       in;
    logic       exp_stall;
    logic       exp_flush;
    logic [1:0] e1a, e2a, e1b, e2b;
    int         exp_sc, exp_fc;
  } vec_t;

  // Reference model: issue history, hist[0] is the instruction now in EX.
  ins_t hist[$];
  int   m_sc, m_fc;
  logic [1:0] m_sel[4];

  function automatic ins_t mk(input logic v, input int rs1, input int rs2,
                              input logic u1, input logic u2, input int rd,
                              input logic rw, input logic mr, input logic pc,
                              input logic imm, input logic ps);
    ins_t i;
    i.valid = v; i.rs1 = 5'(rs1); i.rs2 = 5'(rs2); i.u1 = u1; i.u2 = u2;
    i.rd = 5'(rd); i.rw = rw; i.mr = mr; i.use_pc = pc; i.use_imm = imm;
    i.psel = ps;
    return i;
  endfunction

  function automatic vec_t mv(input ins_t in, input logic st, input logic fl,
                              input int a, input int b, input int c, input int d,
                              input int sc, input int fc);
    vec_t v;
    v.in = in; v.exp_stall = st; v.exp_flush = fl;
    v.e1a = 2'(a); v.e2a = 2'(b); v.e1b = 2'(c); v.e2b = 2'(d);
    v.exp_sc = sc; v.exp_fc = fc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input ins_t i);
    valid_id = i.valid; rs1_id = i.rs1; rs2_id = i.rs2;
    rs1_used_id = i.u1; rs2_used_id = i.u2; rd_id = i.rd;
    reg_write_id = i.rw; mem_read_id = i.mr; use_pc_id = i.use_pc;
    use_imm_id = i.use_imm; pc_select = i.psel;
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] s, input logic used);
    if (!used || s == 5'd0) return 2'd0;
    for (int age = 0; age < hist.size(); age++)
      if (hist[age].valid && hist[age].rw && hist[age].rd == s)
        return (age == 0) ? 2'd3 : 2'd2;
    return 2'd0;
  endfunction

  function automatic logic ref_stall(input ins_t i);
    ins_t p;
    if (!i.valid || i.psel || hist.size() == 0) return 1'b0;
    p = hist[0];
    if (!(p.valid && p.mr && p.rw && p.rd != 5'd0)) return 1'b0;
    return (i.u1 && i.rs1 == p.rd) || (i.u2 && i.rs2 == p.rd);
  endfunction

  task automatic clear_model();
    hist.delete();
    m_sc = 0; m_fc = 0;
    for (int k = 0; k < 4; k++) m_sel[k] = 2'd0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_d1a"}, data1_sel_ALU, m_sel[0]);
    chk({tag, "_d2a"}, data2_sel_ALU, m_sel[1]);
    chk({tag, "_d1b"}, data1_sel_BJ, m_sel[2]);
    chk({tag, "_d2b"}, data2_sel_BJ, m_sel[3]);
    chk({tag, "_scnt"}, stall_count, m_sc);
    chk({tag, "_fcnt"}, flush_count, m_fc);
  endtask

  // One pipeline cycle against the model: called and returns at posedge+1.
  task automatic step(input ins_t i);
    logic st;
    ins_t issued;
    logic [1:0] f1, f2;
    drive(i);
    st = ref_stall(i);
    @(negedge clk);
    chk("stall", stall, st);
    chk("flush_if_id", flush_if_id, i.psel);
    chk("flush_id_ex", flush_id_ex, i.psel);
    f1 = ref_fwd(i.rs1, i.u1);
    f2 = ref_fwd(i.rs2, i.u2);
    issued = i;
    if (i.psel || st || !i.valid) begin
      issued.valid = 1'b0;
      for (int k = 0; k < 4; k++) m_sel[k] = 2'd0;
    end else begin
      m_sel[0] = i.use_pc ? 2'd1 : f1;
      m_sel[1] = i.use_imm ? 2'd1 : f2;
      m_sel[2] = f1;
      m_sel[3] = f2;
    end
    hist.push_front(issued);
    if (hist.size() > 2) void'(hist.pop_back());
    if (st && m_sc < CNT_MAX) m_sc++;
    if (i.psel && m_fc < CNT_MAX) m_fc++;
    @(posedge clk);
    #1;
    check_regs("step");
  endtask

  task automatic do_reset();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", stall, 1'b0);
    check_regs("rst");
    rst_n = 1'b1;
  endtask

  function automatic ins_t rnd_ins();
    return mk($urandom_range(0, 7) != 0, $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 4), $urandom_range(0, 3) != 0,
              $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
  endfunction

  vec_t vecs[20];
  ins_t nop, add5, add9, lw8;

  initial begin
    rst_n = 1'b0;
    nop  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add5 = mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0);
    add9 = mk(1, 8, 1, 1, 1, 9, 1, 0, 0, 0, 0);
    lw8  = mk(1, 1, 0, 1, 0, 8, 1, 1, 0, 1, 0);
    vecs[0]  = mv(add5, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mv(mk(1, 5, 7, 1, 1, 6, 1, 0, 0, 0, 0), 0, 0, 3, 0, 3, 0, 0, 0);
    vecs[2]  = mv(nop, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mv(add5, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mv(nop, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[5]  = mv(mk(1, 5, 5, 1, 1, 0, 0, 0, 0, 0, 0), 0, 0, 2, 2, 2, 2, 0, 0);
    vecs[6]  = mv(lw8, 0, 0, 0, 1, 0, 0, 0, 0);
    vecs[7]  = mv(add9, 1, 0, 0, 0, 0, 0, 1, 0);
    vecs[8]  = mv(add9, 0, 0, 2, 0, 2, 0, 1, 0);
    vecs[9]  = mv(mk(1, 1, 0, 1, 0, 0, 1, 0, 0, 1, 0), 0, 0, 0, 1, 0, 0, 1, 0);
    vecs[10] = mv(mk(1, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0, 1, 0);
    vecs[11] = mv(mk(1, 0, 0, 0, 0, 3, 1, 0, 1, 1, 0), 0, 0, 1, 1, 0, 0, 1, 0);
    vecs[12] = mv(mk(1, 3, 0, 1, 0, 10, 1, 1, 0, 1, 0), 0, 0, 3, 1, 3, 0, 1, 0);
    vecs[13] = mv(mk(1, 10, 10, 1, 1, 11, 1, 0, 0, 0, 1), 0, 1, 0, 0, 0, 0, 1, 1);
    vecs[14] = mv(mk(1, 10, 10, 1, 1, 11, 1, 0, 0, 0, 0), 0, 0, 2, 2, 2, 2, 1, 1);
    vecs[15] = mv(mk(1, 11, 0, 1, 0, 12, 1, 1, 0, 1, 0), 0, 0, 3, 1, 3, 0, 1, 1);
    vecs[16] = mv(mk(1, 12, 0, 1, 0, 13, 1, 1, 0, 1, 0), 1, 0, 0, 0, 0, 0, 2, 1);
    vecs[17] = mv(mk(1, 12, 0, 1, 0, 13, 1, 1, 0, 1, 0), 0, 0, 2, 1, 2, 0, 2, 1);
    vecs[18] = mv(mk(1, 13, 13, 1, 1, 0, 0, 0, 0, 1, 0), 1, 0, 0, 0, 0, 0, 3, 1);
    vecs[19] = mv(mk(1, 13, 13, 1, 1, 0, 0, 0, 0, 1, 0), 0, 0, 2, 1, 2, 2, 3, 1);

    do_reset();

    // Hand-computed pipeline program.
    for (int n = 0; n < 20; n++) begin
      drive(vecs[n].in);
      @(negedge clk);
      chk($sformatf("v%0d_stall", n), stall, vecs[n].exp_stall);
      chk($sformatf("v%0d_flush_if_id", n), flush_if_id, vecs[n].exp_flush);
      chk($sformatf("v%0d_flush_id_ex", n), flush_id_ex, vecs[n].exp_flush);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_d1a", n), data1_sel_ALU, vecs[n].e1a);
      chk($sformatf("v%0d_d2a", n), data2_sel_ALU, vecs[n].e2a);
      chk($sformatf("v%0d_d1b", n), data1_sel_BJ, vecs[n].e1b);
      chk($sformatf("v%0d_d2b", n), data2_sel_BJ, vecs[n].e2b);
      chk($sformatf("v%0d_scnt", n), stall_count, vecs[n].exp_sc);
      chk($sformatf("v%0d_fcnt", n), flush_count, vecs[n].exp_fc);
    end

    // Counter saturation: more stalls and flushes than the counters can hold.
    do_reset();
    for (int n = 0; n < CNT_MAX + 6; n++) begin
      step(lw8);
      step(add9);
    end
    chk("stall_sat", stall_count, CNT_MAX);
    for (int n = 0; n < CNT_MAX + 6; n++) step(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 1));
    chk("flush_sat", flush_count, CNT_MAX);

    // Reset asserted while a load-use stall is in progress.
    step(lw8);
    drive(add9);
    #1;
    chk("midrst_pre_stall", stall, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_stall", stall, 1'b0);
    chk("midrst_scnt", stall_count, 0);
    chk("midrst_fcnt", flush_count, 0);
    chk("midrst_d1a", data1_sel_ALU, 0);
    chk("midrst_d2a", data2_sel_ALU, 0);
    pc_select = 1'b1;
    #1;
    chk("midrst_flush_if_id", flush_if_id, 1'b1);
    chk("midrst_flush_id_ex", flush_id_ex, 1'b1);
    chk("midrst_stall_psel", stall, 1'b0);
    @(posedge clk);
    #1;
    chk("midrst_hold_scnt", stall_count, 0);
    chk("midrst_hold_fcnt", flush_count, 0);
    chk("midrst_hold_d1b", data1_sel_BJ, 0);
    chk("midrst_hold_d2b", data2_sel_BJ, 0);
    drive(nop);
    clear_model();
    rst_n = 1'b1;

    // Random traffic over a small register window to make hazards frequent.
    for (int n = 0; n < 500; n++) step(rnd_ins());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
